potential_adder_driver: RTL and testbench

// - Time-multiplexed neuron sequencer: drives one combinational potential adder (LIF, FP32) on behalf of NUM_NEURONS neurons.
// - Per timestep: pulses clear/set, decays each stored potential and fetches its accumulated weight.
// - Presents both to the adder, captures final_potential/spike, writes the potential back and emits spike events.
// - Sits between the weight accumulator memory (upstream) and the spike router (downstream).

---
 rtl/potential_adder_driver.sv | 141 ++++++++++++++
 tb/tb_potential_adder_driver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/potential_adder_driver.sv
// rtl/potential_adder_driver.sv - time-multiplexed LIF neuron sequencer around one combinational FP32 potential adder
// Optional refractory skipping is enabled by defining REFRACTORY_EN.
module potential_adder_driver #(
  parameter int          NUM_NEURONS  = 30,
  parameter int          ADDR_W       = 5,
  parameter int          ADDER_SETTLE = 2,
  parameter int          DECAY_SHIFT  = 1,
  parameter logic [31:0] V_INIT       = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              timestep_start,
  output logic              busy,
  output logic              done,
  output logic              w_rd,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [31:0]       w_data,
  output logic              clear_adder,
  output logic              set_adder,
  output logic [31:0]       input_weight,
  output logic [31:0]       decayed_potential,
  input  logic [31:0]       final_potential,
  input  logic              spike,
  output logic              spike_valid,
  output logic [ADDR_W-1:0] spike_id,
  input  logic              spike_ready,
  input  logic [ADDR_W-1:0] pot_rd_addr,
  output logic [31:0]       pot_rd_data
);

  localparam int CNT_W = (ADDER_SETTLE > 1) ? $clog2(ADDER_SETTLE + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_SET, S_FETCH, S_DRIVE, S_CAPTURE, S_EMIT, S_NEXT, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  idx;
  logic [CNT_W-1:0]   settle_cnt;
  logic [31:0]        wgt_q;
  logic [31:0]        dec_q;
  logic               clear_hold;
  logic [31:0]        pot [NUM_NEURONS];
  logic               last;
  logic               settled;
  logic               advance;
  logic               skip;

  function automatic logic [31:0] decay(input logic [31:0] v);
    logic [7:0] e;
    e = v[30:23];
    if (e == 8'hFF)
      return v;
    else if (e <= 8'(DECAY_SHIFT))
      return 32'h00000000;
    else
      return {v[31], e - 8'(DECAY_SHIFT), v[22:0]};
  endfunction

  assign last    = (idx == ADDR_W'(NUM_NEURONS - 1));
  assign settled = (settle_cnt == CNT_W'(ADDER_SETTLE - 1));

`ifdef REFRACTORY_EN
  logic [NUM_NEURONS-1:0] refr;

  // A spiking neuron sits out exactly one following timestep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      refr <= '0;
    else if (state == S_CAPTURE)
      refr[idx] <= spike;
    else if (state == S_FETCH && refr[idx])
      refr[idx] <= 1'b0;
  end

  assign skip = refr[idx];
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (timestep_start) state_nx = S_CLEAR;
      S_CLEAR:   state_nx = S_SET;
      S_SET:     state_nx = S_FETCH;
      S_FETCH:   state_nx = skip ? S_NEXT : S_DRIVE;
      S_DRIVE:   if (settled) state_nx = S_CAPTURE;
      S_CAPTURE: begin
        if (spike)     state_nx = S_EMIT;
        else if (last) state_nx = S_DONE;
        else           state_nx = S_FETCH;
      end
      S_EMIT:    if (spike_ready) state_nx = last ? S_DONE : S_FETCH;
      S_NEXT:    state_nx = last ? S_DONE : S_FETCH;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  assign advance = (state_nx == S_FETCH) &&
                   (state == S_CAPTURE || state == S_EMIT || state == S_NEXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      wgt_q      <= '0;
      dec_q      <= '0;
      clear_hold <= 1'b1;
      for (int i = 0; i < NUM_NEURONS; i++) pot[i] <= V_INIT;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && timestep_start) clear_hold <= 1'b0;
      if (state == S_DONE)
        idx <= '0;
      else if (advance)
        idx <= idx + ADDR_W'(1);
      settle_cnt <= (state == S_DRIVE) ? settle_cnt + CNT_W'(1) : '0;
      // Weight memory answers one cycle after the read strobe.
      if (state == S_DRIVE && settle_cnt == '0) wgt_q <= w_data;
      if (state == S_FETCH) dec_q <= decay(pot[idx]);
      if (state == S_CAPTURE) pot[idx] <= final_potential;
    end
  end

  assign busy              = (state != S_IDLE);
  assign done              = (state == S_DONE);
  assign w_rd              = (state == S_FETCH);
  assign w_addr            = (state == S_FETCH) ? idx : '0;
  assign clear_adder       = clear_hold || (state == S_CLEAR);
  assign set_adder         = (state == S_SET);
  // Present the fresh weight straight away so the adder settles for the full hold window.
  assign input_weight      = (state == S_DRIVE && settle_cnt == '0) ? w_data : wgt_q;
  assign decayed_potential = dec_q;
  assign spike_valid       = (state == S_EMIT);
  assign spike_id          = (state == S_EMIT) ? idx : '0;
  assign pot_rd_data       = ({1'b0, pot_rd_addr} < (ADDR_W + 1)'(NUM_NEURONS)) ? pot[pot_rd_addr] : '0;

endmodule

// File: tb/tb_potential_adder_driver.sv
// tb/tb_potential_adder_driver.sv - scoreboard bench for potential_adder_driver (also built with REFRACTORY_EN)
module tb_potential_adder_driver;

  logic        clk, rst;
  logic        ts_a, busy_a, done_a, w_rd_a, clear_a, set_a, spike_a, spike_valid_a, spike_ready;
  logic [1:0]  w_addr_a, spike_id_a, pot_rd_addr;
  logic [31:0] w_data_a, in_w_a, dec_a, fin_a, pot_rd_data;
  logic        ts_b, busy_b, done_b, w_rd_b, clear_b, set_b, spike_valid_b;
  logic [1:0]  w_addr_b, spike_id_b;
  logic [31:0] w_data_b, in_w_b, dec_b, pot_rd_data_b;
  logic [31:0] wmem_a [4];
  logic [31:0] wmem_b [3];
  real         sum_a;

  typedef struct { bit is_done; int id; int cycles; } ev_t;
  ev_t          exp_q[$];
  logic [31:0]  dq[$];
  int checks = 0, errors = 0;
  int cyc_a = 0, stall_left = 0, stall_id_exp = 2;
  bit busy_a_q = 0, w_rd_b_q = 0, stall_on = 0;

  potential_adder_driver #(.NUM_NEURONS(4), .ADDR_W(2), .ADDER_SETTLE(2), .DECAY_SHIFT(0)) u_dut (
    .clk(clk), .rst(rst), .timestep_start(ts_a), .busy(busy_a), .done(done_a),
    .w_rd(w_rd_a), .w_addr(w_addr_a), .w_data(w_data_a), .clear_adder(clear_a), .set_adder(set_a),
    .input_weight(in_w_a), .decayed_potential(dec_a), .final_potential(fin_a), .spike(spike_a),
    .spike_valid(spike_valid_a), .spike_id(spike_id_a), .spike_ready(spike_ready),
    .pot_rd_addr(pot_rd_addr), .pot_rd_data(pot_rd_data));

  potential_adder_driver #(.NUM_NEURONS(3), .ADDR_W(2), .ADDER_SETTLE(2), .DECAY_SHIFT(1)) u_dec (
    .clk(clk), .rst(rst), .timestep_start(ts_b), .busy(busy_b), .done(done_b),
    .w_rd(w_rd_b), .w_addr(w_addr_b), .w_data(w_data_b), .clear_adder(clear_b), .set_adder(set_b),
    .input_weight(in_w_b), .decayed_potential(dec_b), .final_potential(in_w_b), .spike(1'b0),
    .spike_valid(spike_valid_b), .spike_id(spike_id_b), .spike_ready(1'b1),
    .pot_rd_addr(2'd0), .pot_rd_data(pot_rd_data_b));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic real fp2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // LIF adder with threshold 40.0 and subtract-on-spike
  always_comb begin
    sum_a   = fp2r(dec_a) + fp2r(in_w_a);
    spike_a = (sum_a > 40.0);
    fin_a   = r2fp(spike_a ? sum_a - 40.0 : sum_a);
  end

  always @(posedge clk) begin
    if (w_rd_a) w_data_a <= wmem_a[w_addr_a];
    if (w_rd_b) w_data_b <= wmem_b[w_addr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_spike(input int id);
    exp_q.push_back('{is_done: 0, id: id, cycles: 0});
  endtask

  task automatic push_done(input int cyc);
    exp_q.push_back('{is_done: 1, id: 0, cycles: cyc});
  endtask

  // Scoreboard monitor
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (busy_a && !busy_a_q) cyc_a = 1;
      else if (busy_a) cyc_a++;
      busy_a_q = busy_a;
      chk("clear_set_exclusive", {31'd0, clear_a & set_a}, 32'd0);
      if (spike_valid_a && !spike_ready) begin
        chk("stall_no_wrd", {31'd0, w_rd_a}, 32'd0);
        chk("stall_spike_id", {30'd0, spike_id_a}, stall_id_exp);
      end
      if ((spike_valid_a && spike_ready) || done_a) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: done=%0b id=%0d with empty queue", done_a, spike_id_a);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {31'd0, done_a}, {31'd0, e.is_done});
          if (done_a) chk("timestep_cycles", cyc_a, e.cycles);
          else        chk("spike_id", {30'd0, spike_id_a}, e.id);
        end
      end
      if (w_rd_b_q && dq.size() > 0) chk("decayed_potential", dec_b, dq.pop_front());
      w_rd_b_q = w_rd_b;
    end
  end

  task automatic run_a(input int poke);
    int n;
    @(posedge clk); #1 ts_a = 1;
    @(posedge clk); #1 ts_a = 0;
    n = 0;
    while (busy_a && n < 400) begin
      @(posedge clk); #1; n++;
      if (stall_on && spike_valid_a) begin
        if (stall_left == 0) spike_ready = 1;
        else stall_left--;
      end
      if (poke == 1) ts_a = (n == 5);
      if (poke == 2) ts_a = done_a;
    end
    ts_a = 0;
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL timestep_timeout: busy still %0b after %0d cycles", busy_a, n);
    end
    repeat (3) @(posedge clk);
    #1 chk("idle_after_timestep", {31'd0, busy_a}, 32'd0);
  endtask

  task automatic run_b();
    int n;
    @(posedge clk); #1 ts_b = 1;
    @(posedge clk); #1 ts_b = 0;
    n = 0;
    while (busy_b && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL decay_timestep_timeout: busy still %0b", busy_b);
    end
  endtask

  task automatic check_pots(input logic [31:0] e0, e1, e2, e3);
    logic [31:0] ex [4];
    ex = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      pot_rd_addr = 2'(i);
      #1 chk($sformatf("potential[%0d]", i), pot_rd_data, ex[i]);
    end
  endtask

  initial begin
    int n;
    rst = 1; ts_a = 0; ts_b = 0; spike_ready = 1; pot_rd_addr = 0;
    for (int i = 0; i < 4; i++) wmem_a[i] = 32'h41200000;
    wmem_b = '{32'h41A00000, 32'h00800000, 32'h7F800000};
    #1;
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_w_rd", {31'd0, w_rd_a}, 32'd0);
    chk("rst_clear_adder", {31'd0, clear_a}, 32'd1);
    chk("rst_set_adder", {31'd0, set_a}, 32'd0);
    chk("rst_spike_valid", {31'd0, spike_valid_a}, 32'd0);
    chk("rst_input_weight", in_w_a, 32'd0);
    chk("rst_decayed", dec_a, 32'd0);
    chk("rst_potential", pot_rd_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Decay instance: load 20.0 / min-normal / +Inf, then observe decayed operands
    run_b();
    dq.push_back(32'h41200000);
    dq.push_back(32'h00000000);
    dq.push_back(32'h7F800000);
    run_b();
    chk("decay_queue_drained", dq.size(), 32'd0);

    // ts1..ts4: integrate 10.0 each, 40.0 is not above threshold
    push_done(19); run_a(0); check_pots(32'h41200000, 32'h41200000, 32'h41200000, 32'h41200000);
    push_done(19); run_a(1); check_pots(32'h41A00000, 32'h41A00000, 32'h41A00000, 32'h41A00000);
    push_done(19); run_a(0); check_pots(32'h41F00000, 32'h41F00000, 32'h41F00000, 32'h41F00000);
    push_done(19); run_a(2); check_pots(32'h42200000, 32'h42200000, 32'h42200000, 32'h42200000);
    // ts5: every neuron spikes in order
    for (int i = 0; i < 4; i++) push_spike(i);
    push_done(23); run_a(0); check_pots(32'h41200000, 32'h41200000, 32'h41200000, 32'h41200000);
`ifdef REFRACTORY_EN
    push_done(11); run_a(0); check_pots(32'h41200000, 32'h41200000, 32'h41200000, 32'h41200000);
`else
    push_done(19); run_a(0); check_pots(32'h41A00000, 32'h41A00000, 32'h41A00000, 32'h41A00000);
`endif
    // ts7: only id 2 spikes, downstream stalls 20 cycles
    wmem_a[2] = 32'h42200000;
    spike_ready = 0; stall_on = 1; stall_left = 20;
    push_spike(2); push_done(40); run_a(0);
    stall_on = 0; spike_ready = 1;
`ifdef REFRACTORY_EN
    check_pots(32'h41A00000, 32'h41A00000, 32'h41200000, 32'h41A00000);
`else
    check_pots(32'h41F00000, 32'h41F00000, 32'h41A00000, 32'h41F00000);
`endif

    // Abort during DRIVE of id 1
    wmem_a[2] = 32'h41200000;
    @(posedge clk); #1 ts_a = 1;
    @(posedge clk); #1 ts_a = 0;
    n = 0;
    while (!(w_rd_a && w_addr_a == 2'd1) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("reached_fetch_id1", {31'd0, w_rd_a}, 32'd1);
    @(posedge clk); #1 rst = 1;
    #1;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_clear_adder", {31'd0, clear_a}, 32'd1);
    check_pots(32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 chk("abort_stays_idle", {31'd0, busy_a}, 32'd0);
    push_done(19); run_a(0); check_pots(32'h41200000, 32'h41200000, 32'h41200000, 32'h41200000);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
